lrshift_engine: RTL

Parametrised successor to the 16-bit left/right shifter. Holds a WIDTH-bit register that is parallel-loaded, then shifted or rotated left or right by a programmable amount under a start/busy/done handshake. By default it performs one bit-step per clock; a compile-time option selects single-step barrel shifting. It sits on the datapath wherever a multi-bit shift with a completion handshake is needed.

---
 rtl/lrshift_pkg.sv | 23 ++
 rtl/lrshift_engine_if.sv | 35 +++
 rtl/lrshift_step.sv | 68 ++++++
 rtl/lrshift_engine.sv | 114 +++++++++++
 4 files changed

// File: rtl/lrshift_pkg.sv
// lrshift_pkg: shared definitions for the lrshift_engine block.
//   - lrs_mode_t : operation mode encodings (logical, rotate, arithmetic, hold)
//   - LRS_DIR_*  : direction constants (left = toward MSB)
//   - lrs_state_t: control FSM states (IDLE, SHIFT, DONE)
package lrshift_pkg;

  typedef enum logic [1:0] {
    LRS_LOGIC = 2'b00,
    LRS_ROT   = 2'b01,
    LRS_ARITH = 2'b10,
    LRS_HOLD  = 2'b11
  } lrs_mode_t;

  localparam logic LRS_DIR_LEFT  = 1'b0;
  localparam logic LRS_DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } lrs_state_t;

endpackage

// File: rtl/lrshift_engine_if.sv
// lrshift_engine_if: control/data bundle of the shift engine.
//   master (requester): drives load, din, d, direction, mode, amount, start;
//                       observes busy, done, out, sout.
//   slave  (engine)   : the mirror image.
// Handshake: start is a single-cycle request accepted only while the engine
// is idle (busy=0, done=0); completion is signalled by a one-cycle done pulse,
// and the requester must not expect a new start to be taken before the edge
// that follows the done cycle. load is likewise honoured only while idle and
// wins over a simultaneous start.
interface lrshift_engine_if #(
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(WIDTH)
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             d;
  logic             direction;
  logic [1:0]       mode;
  logic [AW-1:0]    amount;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             sout;

  modport master (
    output load, din, d, direction, mode, amount, start,
    input  busy, done, out, sout
  );

  modport slave (
    input  load, din, d, direction, mode, amount, start,
    output busy, done, out, sout
  );
endinterface

// File: rtl/lrshift_step.sv
// lrshift_step: combinational shift/rotate datapath.
// Applies i_count bit positions of shift/rotate/fill to i_value and reports
// the last bit to leave the register.
//   i_value : current register contents
//   i_dir   : LRS_DIR_LEFT / LRS_DIR_RIGHT
//   i_mode  : lrs_mode_t operation
//   i_fill  : serial fill bit for logical mode (replicated into every vacated bit)
//   i_count : number of positions (0 returns the value unchanged)
//   o_value : shifted value
//   o_exit  : last exiting bit (bit WIDTH-n for left, bit n-1 for right)
module lrshift_step
  import lrshift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dir,
  input  lrs_mode_t        i_mode,
  input  logic             i_fill,
  input  logic [AW-1:0]    i_count,
  output logic [WIDTH-1:0] o_value,
  output logic             o_exit
);

  localparam logic [WIDTH-1:0] ONES = '1;

  int unsigned       w_n;
  logic [WIDTH-1:0]  w_fill_lo;   // low n bits set
  logic [WIDTH-1:0]  w_fill_hi;   // high n bits set
  logic [AW-1:0]     w_lidx;
  logic [AW-1:0]     w_ridx;

  always_comb begin
    w_n       = 32'(i_count);
    w_fill_lo = '0;
    w_fill_hi = '0;
    w_lidx    = '0;
    w_ridx    = '0;
    o_value   = i_value;
    o_exit    = 1'b0;
    if (w_n != 0) begin
      w_fill_lo = ONES >> (WIDTH - w_n);
      w_fill_hi = ONES << (WIDTH - w_n);
      w_lidx    = AW'(WIDTH - w_n);
      w_ridx    = i_count - AW'(1);
      if (i_dir == LRS_DIR_LEFT) begin
        o_exit = i_value[w_lidx];
        case (i_mode)
          LRS_LOGIC: o_value = (i_value << w_n) | (i_fill ? w_fill_lo : '0);
          LRS_ROT:   o_value = (i_value << w_n) | (i_value >> (WIDTH - w_n));
          LRS_ARITH: o_value = i_value << w_n;
          default:   o_value = i_value;
        endcase
      end else begin
        o_exit = i_value[w_ridx];
        case (i_mode)
          LRS_LOGIC: o_value = (i_value >> w_n) | (i_fill ? w_fill_hi : '0);
          LRS_ROT:   o_value = (i_value >> w_n) | (i_value << (WIDTH - w_n));
          // Sign extension: vacated high bits copy the original MSB.
          LRS_ARITH: o_value = (i_value >> w_n) | (i_value[WIDTH-1] ? w_fill_hi : '0);
          default:   o_value = i_value;
        endcase
      end
    end
  end

endmodule

// File: rtl/lrshift_engine.sv
// lrshift_engine: WIDTH-bit shift/rotate register with start/busy/done handshake.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset (aborts any operation, no done)
//   bus         : lrshift_engine_if.slave (load/din/d/direction/mode/amount/start
//                 in; busy/done/out/sout out)
//   o_dbg_state : current FSM state
// Build option: define LRSHIFT_BARREL_EN to apply the full shift amount in one
// SHIFT cycle; otherwise one bit position is applied per clock.
module lrshift_engine
  import lrshift_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(WIDTH)
) (
  input  logic                clk,
  input  logic                reset,
  lrshift_engine_if.slave     bus,
  output lrs_state_t          o_dbg_state
);

  lrs_state_t       r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_sout;
  logic             r_busy;
  logic             r_done;
  logic             r_dir;
  lrs_mode_t        r_mode;
  logic [AW-1:0]    r_cnt;

  logic [AW-1:0]    w_count;
  logic             w_last;
  logic [WIDTH-1:0] w_next;
  logic             w_exit;

`ifdef LRSHIFT_BARREL_EN
  // The whole amount is consumed by the single SHIFT cycle.
  assign w_count = r_cnt;
  assign w_last  = 1'b1;
`else
  assign w_count = AW'(1);
  assign w_last  = (r_cnt == AW'(1));
`endif

  lrshift_step #(.WIDTH(WIDTH)) u_step (
    .i_value (r_out),
    .i_dir   (r_dir),
    .i_mode  (r_mode),
    .i_fill  (bus.d),
    .i_count (w_count),
    .o_value (w_next),
    .o_exit  (w_exit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_out   <= '0;
      r_sout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dir   <= LRS_DIR_LEFT;
      r_mode  <= LRS_LOGIC;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.load) begin
            // load has priority; a simultaneous start is dropped
            r_out <= bus.din;
          end else if (bus.start) begin
            r_dir  <= bus.direction;
            r_mode <= lrs_mode_t'(bus.mode);
            r_cnt  <= bus.amount;
            if (bus.amount == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= SHIFT;
              r_busy  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_out <= w_next;
          if (r_mode != LRS_HOLD) r_sout <= w_exit;
          r_cnt <= r_cnt - AW'(1);
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.sout    = r_sout;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign o_dbg_state = r_state;

endmodule
